// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target.
package i2c_pkg;

    localparam int   I2C_ADDR_W = 7;
    localparam logic I2C_ACK    = 1'b0;
    localparam logic I2C_NACK   = 1'b1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        ADDR_ACK  = 3'd2,
        RX_DATA   = 3'd3,
        RX_ACK    = 3'd4,
        TX_DATA   = 3'd5,
        TX_ACK    = 3'd6,
        WAIT_STOP = 3'd7
    } i2c_tgt_state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// Oversampled SCL/SDA front end: synchronizers, history flops and
// registered edge / START / STOP events.
module i2c_bus_sync (
    input  logic clk_400,
    input  logic rst_n,
    input  logic SCL,
    input  logic SDA,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det_i,
    output logic sda_s
);

    logic scl_meta_r, scl_sync_r, scl_hist_r;
    logic sda_meta_r, sda_sync_r, sda_hist_r;

    // Synchronize both pins and decode bus events one cycle later
    always_ff @(posedge clk_400) begin
        if (!rst_n) begin
            // Idle-bus values so a reset never manufactures an edge
            scl_meta_r <= 1'b1;
            scl_sync_r <= 1'b1;
            scl_hist_r <= 1'b1;
            sda_meta_r <= 1'b1;
            sda_sync_r <= 1'b1;
            sda_hist_r <= 1'b1;
            scl_rise   <= 1'b0;
            scl_fall   <= 1'b0;
            start_det  <= 1'b0;
            stop_det_i <= 1'b0;
            sda_s      <= 1'b1;
        end else begin
            scl_meta_r <= SCL;
            scl_sync_r <= scl_meta_r;
            scl_hist_r <= scl_sync_r;
            sda_meta_r <= SDA;
            sda_sync_r <= sda_meta_r;
            sda_hist_r <= sda_sync_r;
            scl_rise   <= scl_sync_r & ~scl_hist_r;
            scl_fall   <= ~scl_sync_r & scl_hist_r;
            start_det  <= scl_sync_r & scl_hist_r & sda_hist_r & ~sda_sync_r;
            stop_det_i <= scl_sync_r & scl_hist_r & ~sda_hist_r & sda_sync_r;
            sda_s      <= sda_sync_r;
        end
    end

endmodule

// File: rtl/i2c_target.sv
// I2C target answering one 7-bit address: receives write bytes and
// serves read bytes from local logic over an open-drain SDA.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] TARGET_ADDR = 7'h50
) (
    input  logic       clk_400,
    input  logic       rst_n,
    input  logic       SCL,
    inout  wire        SDA,
    input  logic [7:0] tx_data,
    output logic       tx_next,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       addressed,
    output logic       rw,
    output logic       nack_rx,
    output logic       stop_det,
    output logic       busy
);

    logic scl_rise_s, scl_fall_s, start_det_s, stop_det_s, sda_s;

    i2c_tgt_state_t state_r;
    logic [2:0]     bit_cnt_r;
    logic [7:0]     shift_r;
    logic           byte_done_r;
    logic           addr_match_r;
    logic           sda_oe_r;

    i2c_bus_sync u_bus_sync (
        .clk_400    (clk_400),
        .rst_n      (rst_n),
        .SCL        (SCL),
        .SDA        (SDA),
        .scl_rise   (scl_rise_s),
        .scl_fall   (scl_fall_s),
        .start_det  (start_det_s),
        .stop_det_i (stop_det_s),
        .sda_s      (sda_s)
    );

    assign SDA = sda_oe_r ? I2C_ACK : 1'bz;

    // Transfer FSM; byte_done_r marks "8 bits shifted" in ADDR/RX_DATA
    // and "controller ACKed" in TX_ACK
    always_ff @(posedge clk_400) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            bit_cnt_r    <= 3'd7;
            shift_r      <= 8'h00;
            byte_done_r  <= 1'b0;
            addr_match_r <= 1'b0;
            sda_oe_r     <= 1'b0;
            tx_next      <= 1'b0;
            rx_data      <= 8'h00;
            rx_valid     <= 1'b0;
            addressed    <= 1'b0;
            rw           <= 1'b0;
            nack_rx      <= 1'b0;
            stop_det     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            tx_next  <= 1'b0;
            rx_valid <= 1'b0;
            nack_rx  <= 1'b0;
            stop_det <= 1'b0;
            if (stop_det_s) begin
                state_r   <= IDLE;
                stop_det  <= 1'b1;
                addressed <= 1'b0;
                sda_oe_r  <= 1'b0;
                busy      <= 1'b0;
            end else if (start_det_s) begin
                state_r     <= ADDR;
                bit_cnt_r   <= 3'd7;
                byte_done_r <= 1'b0;
                addressed   <= 1'b0;
                sda_oe_r    <= 1'b0;
                busy        <= 1'b1;
            end else begin
                case (state_r)
                    IDLE, WAIT_STOP: begin
                        sda_oe_r <= 1'b0;
                    end
                    ADDR: begin
                        if (scl_rise_s) begin
                            shift_r <= {shift_r[6:0], sda_s};
                            if (bit_cnt_r == 3'd0) begin
                                byte_done_r  <= 1'b1;
                                rw           <= sda_s;
                                addr_match_r <= (shift_r[6:0] == TARGET_ADDR);
                            end else begin
                                bit_cnt_r <= bit_cnt_r - 3'd1;
                            end
                        end else if (scl_fall_s && byte_done_r) begin
                            byte_done_r <= 1'b0;
                            if (addr_match_r) begin
                                sda_oe_r  <= 1'b1;
                                addressed <= 1'b1;
                                state_r   <= ADDR_ACK;
                            end else begin
                                sda_oe_r <= 1'b0;
                                state_r  <= WAIT_STOP;
                            end
                        end else begin
                            state_r <= ADDR;
                        end
                    end
                    ADDR_ACK, TX_ACK: begin
                        if (state_r == TX_ACK && scl_rise_s) begin
                            if (sda_s == I2C_ACK) begin
                                byte_done_r <= 1'b1;
                            end else begin
                                nack_rx  <= 1'b1;
                                sda_oe_r <= 1'b0;
                                state_r  <= WAIT_STOP;
                            end
                        end else if (scl_fall_s && state_r == ADDR_ACK && !rw) begin
                            sda_oe_r    <= 1'b0;
                            bit_cnt_r   <= 3'd7;
                            byte_done_r <= 1'b0;
                            state_r     <= RX_DATA;
                        end else if (scl_fall_s && (state_r == ADDR_ACK || byte_done_r)) begin
                            shift_r     <= tx_data;
                            tx_next     <= 1'b1;
                            sda_oe_r    <= ~tx_data[7];
                            bit_cnt_r   <= 3'd7;
                            byte_done_r <= 1'b0;
                            state_r     <= TX_DATA;
                        end else begin
                            state_r <= state_r;
                        end
                    end
                    RX_DATA: begin
                        if (scl_rise_s) begin
                            shift_r <= {shift_r[6:0], sda_s};
                            if (bit_cnt_r == 3'd0) begin
                                byte_done_r <= 1'b1;
                            end else begin
                                bit_cnt_r <= bit_cnt_r - 3'd1;
                            end
                        end else if (scl_fall_s && byte_done_r) begin
                            rx_data     <= shift_r;
                            rx_valid    <= 1'b1;
                            sda_oe_r    <= 1'b1;
                            byte_done_r <= 1'b0;
                            state_r     <= RX_ACK;
                        end else begin
                            state_r <= RX_DATA;
                        end
                    end
                    RX_ACK: begin
                        if (scl_fall_s) begin
                            sda_oe_r  <= 1'b0;
                            bit_cnt_r <= 3'd7;
                            state_r   <= RX_DATA;
                        end else begin
                            state_r <= RX_ACK;
                        end
                    end
                    TX_DATA: begin
                        if (scl_fall_s) begin
                            if (bit_cnt_r == 3'd0) begin
                                sda_oe_r    <= 1'b0;
                                byte_done_r <= 1'b0;
                                state_r     <= TX_ACK;
                            end else begin
                                sda_oe_r  <= ~shift_r[6];
                                shift_r   <= {shift_r[6:0], 1'b0};
                                bit_cnt_r <= bit_cnt_r - 3'd1;
                            end
                        end else begin
                            state_r <= TX_DATA;
                        end
                    end
                    default: begin
                        sda_oe_r <= 1'b0;
                        state_r  <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Self-checking bench for i2c_target: bit-banged bus controller plus
// scoreboards for received and transmitted bytes.
`timescale 1ns/1ps
module tb_i2c_target;

    logic       clk_400 = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       ctrl_sda_low = 1'b0;
    wire        SDA;
    logic [7:0] tx_data;
    logic       tx_next, rx_valid, addressed, rw, nack_rx, stop_det, busy;
    logic [7:0] rx_data;

    int n_tests = 0;
    int n_fail = 0;
    int rx_cnt = 0, tx_cnt = 0, nack_cnt = 0, stop_cnt = 0, tgt_low_cnt = 0;
    logic [7:0] exp_rx_q[$];
    logic [7:0] exp_tx_q[$];
    logic [7:0] tx_tab [8] = '{8'h96, 8'h0F, 8'h22, 8'hC3, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [2:0] tx_ptr = 3'd0;
    logic       prev_rxv = 1'b0, prev_txn = 1'b0, prev_stop = 1'b0, prev_nack = 1'b0;

    assign SDA = ctrl_sda_low ? 1'b0 : 1'bz;
    pullup (SDA);
    assign tx_data = tx_tab[tx_ptr];

    always #5 clk_400 = ~clk_400;

    i2c_target #(.TARGET_ADDR(7'h50)) dut (
        .clk_400   (clk_400),
        .rst_n     (rst_n),
        .SCL       (scl),
        .SDA       (SDA),
        .tx_data   (tx_data),
        .tx_next   (tx_next),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .addressed (addressed),
        .rw        (rw),
        .nack_rx   (nack_rx),
        .stop_det  (stop_det),
        .busy      (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_400);
        #1;
    endtask

    task automatic bus_start();
        ctrl_sda_low = 1'b0;
        scl = 1'b1;
        wait_cyc(8);
        ctrl_sda_low = 1'b1;
        wait_cyc(8);
        scl = 1'b0;
        wait_cyc(4);
    endtask

    task automatic bus_stop();
        ctrl_sda_low = 1'b1;
        wait_cyc(4);
        scl = 1'b1;
        wait_cyc(8);
        ctrl_sda_low = 1'b0;
        wait_cyc(8);
    endtask

    task automatic write_bit(input logic b);
        ctrl_sda_low = ~b;
        wait_cyc(4);
        scl = 1'b1;
        wait_cyc(8);
        scl = 1'b0;
        wait_cyc(4);
    endtask

    task automatic read_bit(output logic b);
        ctrl_sda_low = 1'b0;
        wait_cyc(4);
        scl = 1'b1;
        wait_cyc(4);
        b = SDA;
        wait_cyc(4);
        scl = 1'b0;
        wait_cyc(4);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack_bit);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(ack_bit);
    endtask

    // Event monitor and scoreboard for pulses, rx bytes and target-driven lows
    always @(negedge clk_400) begin
        logic [8:0] exp_rx;
        if (rx_valid) begin
            rx_cnt++;
            check_eq("rxv_width", {31'd0, prev_rxv}, 32'd0);
            check_eq("rxv_txn_excl", {31'd0, tx_next}, 32'd0);
            exp_rx = (exp_rx_q.size() > 0) ? {1'b0, exp_rx_q.pop_front()} : 9'h100;
            check_eq("rx_data", {24'd0, rx_data}, {23'd0, exp_rx});
        end
        if (tx_next) begin
            tx_cnt++;
            check_eq("txn_width", {31'd0, prev_txn}, 32'd0);
            tx_ptr <= tx_ptr + 3'd1;
        end
        if (stop_det) begin
            stop_cnt++;
            check_eq("stop_width", {31'd0, prev_stop}, 32'd0);
        end
        if (nack_rx) begin
            nack_cnt++;
            check_eq("nack_width", {31'd0, prev_nack}, 32'd0);
        end
        if (SDA === 1'b0 && !ctrl_sda_low) tgt_low_cnt++;
        prev_rxv  <= rx_valid;
        prev_txn  <= tx_next;
        prev_stop <= stop_det;
        prev_nack <= nack_rx;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ack;
        logic [7:0] rd;
        logic       b;
        int         rx0, tx0, nk0, st0, low0;

        // Reset state
        wait_cyc(5);
        check_eq("reset_outs", {24'd0, tx_next, rx_valid, addressed, rw, nack_rx, stop_det, busy, 1'b0},
                 32'd0);
        check_eq("reset_rx_data", {24'd0, rx_data}, 32'd0);
        check_eq("reset_sda", {31'd0, SDA}, 32'd1);
        rst_n = 1'b1;
        wait_cyc(5);

        // Write 0xA5, 0x3C
        rx0 = rx_cnt; st0 = stop_cnt;
        bus_start();
        check_eq("wr_busy", {31'd0, busy}, 32'd1);
        write_byte(8'hA0, ack);
        check_eq("wr_addr_ack", {31'd0, ack}, 32'd0);
        check_eq("wr_addressed", {31'd0, addressed}, 32'd1);
        check_eq("wr_rw", {31'd0, rw}, 32'd0);
        exp_rx_q.push_back(8'hA5);
        write_byte(8'hA5, ack);
        check_eq("wr_ack1", {31'd0, ack}, 32'd0);
        exp_rx_q.push_back(8'h3C);
        write_byte(8'h3C, ack);
        check_eq("wr_ack2", {31'd0, ack}, 32'd0);
        bus_stop();
        check_eq("wr_rx_cnt", rx_cnt - rx0, 32'd2);
        check_eq("wr_stop_cnt", stop_cnt - st0, 32'd1);
        check_eq("wr_busy_end", {31'd0, busy}, 32'd0);
        check_eq("wr_addressed_end", {31'd0, addressed}, 32'd0);

        // Read 0x96 (ACK) then 0x0F (NACK)
        tx0 = tx_cnt; nk0 = nack_cnt;
        exp_tx_q.push_back(8'h96);
        exp_tx_q.push_back(8'h0F);
        bus_start();
        write_byte(8'hA1, ack);
        check_eq("rd_addr_ack", {31'd0, ack}, 32'd0);
        check_eq("rd_rw", {31'd0, rw}, 32'd1);
        read_byte(rd, 1'b0);
        check_eq("rd_byte0", {24'd0, rd}, {24'd0, exp_tx_q.pop_front()});
        read_byte(rd, 1'b1);
        check_eq("rd_byte1", {24'd0, rd}, {24'd0, exp_tx_q.pop_front()});
        wait_cyc(4);
        check_eq("rd_sda_released", {31'd0, SDA}, 32'd1);
        check_eq("rd_tx_next_cnt", tx_cnt - tx0, 32'd2);
        check_eq("rd_nack_cnt", nack_cnt - nk0, 32'd1);
        bus_stop();

        // Address mismatch
        rx0 = rx_cnt; low0 = tgt_low_cnt;
        bus_start();
        write_byte(8'hB0, ack);
        check_eq("mm_addr_nack", {31'd0, ack}, 32'd1);
        check_eq("mm_addressed", {31'd0, addressed}, 32'd0);
        write_byte(8'h77, ack);
        check_eq("mm_data_nack", {31'd0, ack}, 32'd1);
        bus_stop();
        check_eq("mm_no_sda_low", tgt_low_cnt - low0, 32'd0);
        check_eq("mm_no_rx", rx_cnt - rx0, 32'd0);

        // Repeated start: write 0x11, then read 0x22
        bus_start();
        write_byte(8'hA0, ack);
        check_eq("rs_addr_ack", {31'd0, ack}, 32'd0);
        exp_rx_q.push_back(8'h11);
        write_byte(8'h11, ack);
        check_eq("rs_wr_ack", {31'd0, ack}, 32'd0);
        exp_tx_q.push_back(8'h22);
        bus_start();
        write_byte(8'hA1, ack);
        check_eq("rs_addr2_ack", {31'd0, ack}, 32'd0);
        check_eq("rs_rw", {31'd0, rw}, 32'd1);
        check_eq("rs_rx_data", {24'd0, rx_data}, 32'h11);
        read_byte(rd, 1'b1);
        check_eq("rs_rd_byte", {24'd0, rd}, {24'd0, exp_tx_q.pop_front()});
        bus_stop();

        // Reset during the 4th bit of a read byte (0xC3, bit is 0)
        bus_start();
        write_byte(8'hA1, ack);
        check_eq("rst_addr_ack", {31'd0, ack}, 32'd0);
        for (int i = 0; i < 3; i++) read_bit(b);
        wait_cyc(4);
        check_eq("rst_bit_driven", {31'd0, SDA}, 32'd0);
        scl = 1'b1;
        wait_cyc(2);
        rst_n = 1'b0;
        wait_cyc(1);
        check_eq("rst_sda_released", {31'd0, SDA}, 32'd1);
        check_eq("rst_outs", {24'd0, tx_next, rx_valid, addressed, rw, nack_rx, stop_det, busy, 1'b0},
                 32'd0);
        check_eq("rst_rx_data", {24'd0, rx_data}, 32'd0);
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(2);
        scl = 1'b0;
        wait_cyc(4);
        bus_stop();
        bus_start();
        write_byte(8'hA0, ack);
        check_eq("post_rst_addr_ack", {31'd0, ack}, 32'd0);
        exp_rx_q.push_back(8'h5A);
        write_byte(8'h5A, ack);
        check_eq("post_rst_ack", {31'd0, ack}, 32'd0);
        bus_stop();

        // STOP after 3 data bits of a write
        rx0 = rx_cnt; st0 = stop_cnt;
        bus_start();
        write_byte(8'hA0, ack);
        check_eq("sm_addr_ack", {31'd0, ack}, 32'd0);
        write_bit(1'b1);
        write_bit(1'b0);
        write_bit(1'b1);
        bus_stop();
        check_eq("sm_stop_cnt", stop_cnt - st0, 32'd1);
        check_eq("sm_no_rx", rx_cnt - rx0, 32'd0);
        check_eq("sm_busy", {31'd0, busy}, 32'd0);
        check_eq("sm_addressed", {31'd0, addressed}, 32'd0);

        wait_cyc(4);
        check_eq("rx_q_drained", exp_rx_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
